// File: rtl/iob_tdp_ram_fifo_ctrl_if.sv
// FIFO user-side bus of iob_tdp_ram_fifo_ctrl: write/read requests, data, flags and occupancy.
// The controller takes the slave modport; the producer/consumer logic takes the master modport.
interface iob_tdp_ram_fifo_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              w_en;
    logic [DATA_W-1:0] w_data;
    logic              w_full;
    logic              r_en;
    logic [DATA_W-1:0] r_data;
    logic              r_empty;
    logic [ADDR_W:0]   level;

    modport master (
        output w_en, w_data, r_en,
        input  w_full, r_data, r_empty, level
    );

    modport slave (
        input  w_en, w_data, r_en,
        output w_full, r_data, r_empty, level
    );
endinterface

// File: rtl/iob_tdp_ram_fifo_ctrl.sv
// Synchronous FIFO controller driving an external true dual-port RAM (port A write, port B read).
// Optional sticky overflow/underflow outputs are enabled with `define IOB_FIFO_ERR_FLAGS_EN.
module iob_tdp_ram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    iob_tdp_ram_fifo_ctrl_if.slave fifo,
    output logic                  ext_mem_en_a,
    output logic                  ext_mem_we_a,
    output logic [ADDR_W-1:0]     ext_mem_addr_a,
    output logic [DATA_W-1:0]     ext_mem_data_a,
    output logic                  ext_mem_en_b,
    output logic [ADDR_W-1:0]     ext_mem_addr_b,
    input  logic [DATA_W-1:0]     ext_mem_q_b
`ifdef IOB_FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam logic [ADDR_W:0] DEPTH   = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    // Pointers carry one extra wrap bit above the RAM address.
    logic [ADDR_W:0] wptr;
    logic [ADDR_W:0] rptr;
    logic [ADDR_W:0] level_q;
    logic            w_ack;
    logic            r_ack;

    // Flags come from registered occupancy only, so requests never feed back into them.
    assign fifo.w_full  = (level_q == DEPTH);
    assign fifo.r_empty = (level_q == '0);
    assign fifo.level   = level_q;
    assign fifo.r_data  = ext_mem_q_b;

    assign w_ack = fifo.w_en & ~fifo.w_full  & ~rst;
    assign r_ack = fifo.r_en & ~fifo.r_empty & ~rst;

    assign ext_mem_en_a   = w_ack;
    assign ext_mem_we_a   = w_ack;
    assign ext_mem_addr_a = wptr[ADDR_W-1:0];
    assign ext_mem_data_a = fifo.w_data;
    assign ext_mem_en_b   = r_ack;
    assign ext_mem_addr_b = rptr[ADDR_W-1:0];

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
        end else begin
            if (w_ack) wptr <= wptr + CNT_ONE;
            if (r_ack) rptr <= rptr + CNT_ONE;
            unique case ({w_ack, r_ack})
                2'b10:   level_q <= level_q + CNT_ONE;
                2'b01:   level_q <= level_q - CNT_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

`ifdef IOB_FIFO_ERR_FLAGS_EN
    // Sticky: once an illegal request is seen it stays flagged until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (fifo.w_en & fifo.w_full)  overflow  <= 1'b1;
            if (fifo.r_en & fifo.r_empty) underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/iob_tdp_ram_fifo_ctrl.md
Name: iob_tdp_ram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly upstream of the true dual-port RAM (iob_tdp_ram) and drives both of its ports.
- Port A is the write port; port B is the read port.
- Owns the read/write pointers, the occupancy counter and the full/empty flags.
- Read data is the RAM port-B output passed straight through. The RAM is instantiated alongside this block, not inside it.

Parameters:
- DATA_W, 8, FIFO word width; equals the RAM DATA_W.
- ADDR_W, 4, RAM address width; FIFO depth = 2**ADDR_W.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- w_en  in  1  write request.
- w_data  in  DATA_W  write word.
- w_full  out  1  FIFO full.
- r_en  in  1  read request.
- r_data  out  DATA_W  read word; valid 1 cycle after an accepted read.
- r_empty  out  1  FIFO empty.
- level  out  ADDR_W+1  current occupancy, 0..2**ADDR_W.
- ext_mem_en_a  out  1  RAM port A enable.
- ext_mem_we_a  out  1  RAM port A write enable.
- ext_mem_addr_a  out  ADDR_W  RAM port A address.
- ext_mem_data_a  out  DATA_W  RAM port A write data.
- ext_mem_en_b  out  1  RAM port B enable.
- ext_mem_addr_b  out  ADDR_W  RAM port B address.
- ext_mem_q_b  in  DATA_W  RAM port B registered read data.

Behaviour:
- State: wptr and rptr, each ADDR_W+1 bits; level register, ADDR_W+1 bits.
- RAM addresses: ext_mem_addr_a = wptr[ADDR_W-1:0]; ext_mem_addr_b = rptr[ADDR_W-1:0]. MSB of each pointer is the wrap bit.
- Flags: r_empty = (level==0); w_full = (level==2**ADDR_W). Both are derived from registered state only; no combinational path from w_en/r_en.
- Write acceptance: w_ack = w_en & ~w_full & ~rst.
  - ext_mem_en_a = ext_mem_we_a = w_ack (combinational).
  - ext_mem_data_a = w_data.
  - On w_ack, wptr increments at the clock edge.
- Read acceptance: r_ack = r_en & ~r_empty & ~rst.
  - ext_mem_en_b = r_ack.
  - On r_ack, rptr increments.
  - r_data = ext_mem_q_b; the word appears on the cycle after r_ack and holds until the next accepted read (RAM holds q_b while en_b=0).
- Level update: +1 on w_ack only; -1 on r_ack only; unchanged when both or neither.
- Simultaneous read and write:
  - When full: the read is accepted and the write is rejected (flags are evaluated on the pre-edge state).
  - When empty: the write is accepted and the read is rejected; that word is readable from the next cycle.
- Writing to full or reading from empty is ignored: no pointer or level change, no RAM access.
- Pointer wrap: pointers roll over 2**(ADDR_W+1)-1 -> 0 naturally. RAM addresses wrap 2**ADDR_W-1 -> 0.
- Reset values: wptr=0, rptr=0, level=0, r_empty=1, w_full=0, all ext_mem_en/we outputs 0.
  - RAM contents are not cleared; r_data reflects the RAM's q_b, which is don't-care until the first read.
- Reset mid-operation: a write or read presented in the rst cycle is dropped. The FIFO is empty on the cycle after rst.
- No state machine beyond the counters; latency is write-to-readable 1 cycle, read-to-data 1 cycle.

Optional Feature:
- Macro: IOB_FIFO_ERR_FLAGS_EN.
- Defined: adds output ports overflow (1) and underflow (1), both sticky and reset to 0 by rst.
  - overflow sets on the edge where w_en & w_full.
  - underflow sets on the edge where r_en & r_empty.
  - Both stay set until rst.
- Undefined: ports and logic are absent; illegal requests are silently ignored as above.

Test Plan (ADDR_W=4, DATA_W=8, controller connected to iob_tdp_ram):
- Reset: assert rst 2 cycles -> level=0, r_empty=1, w_full=0, ext_mem_en_a=ext_mem_en_b=0.
- Fill: write 0x10..0x1F over 16 cycles -> level=16, w_full=1 after the 16th edge. A 17th write of 0xAA leaves level=16, no ext_mem_en_a pulse, overflow=1 if enabled.
- Drain: read 16 times -> r_data sequence 0x10..0x1F, each 1 cycle after its r_en. r_empty=1 after the last. A 17th read gives no ext_mem_en_b pulse, r_data holds 0x1F, underflow=1 if enabled.
- Simultaneous: with level=5, assert w_en+r_en for 10 cycles -> level stays 5 and the data order is preserved. With level=16 plus both asserted -> level=15. With level=0 plus both asserted -> level=1 and r_data is not updated.
- Wrap: 40 write/read pairs of 0x00..0x27 at level around 3 -> all words read back in order across both pointer wraps.
- Mid-operation reset: at level=7, assert rst with w_en=1 -> next cycle level=0, r_empty=1. Write 0x55 then read -> r_data=0x55.
